// File: rtl/gate_tester_pkg.sv
// Shared definitions for the 2-input gate self-test engine.
package gate_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 4;

  // Expected truth tables, bit i = gate output for {a,b} == i.
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_tester.sv
// Sweeps the four input combinations of a 2-input gate, holds each for
// SETTLE_CYCLES cycles, samples the gate output on the last settle edge and
// accumulates a per-vector mismatch mask plus an overall pass flag.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = NAND_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch,
  output logic [1:0] vec_idx
);

  // Settle counter value on the edge that ends a vector's hold window.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [1:0] idx_q,   idx_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       pass_q,  pass_d;
  logic [3:0] mm_q,    mm_d;

  // Next-state logic: idx doubles as the driven vector and returns to 0
  // whenever vectors are not being applied, so the gate inputs idle low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mm_d    = mm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          cnt_d   = 8'd0;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mm_d    = 4'b0000;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          // Sample point: the gate has had SETTLE_CYCLES cycles to respond.
          cnt_d       = 8'd0;
          mm_d[idx_q] = mm_q[idx_q] | (dut_out != EXPECT[idx_q]);
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_d == 4'b0000);
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
    end
  end

  assign dut_a    = idx_q[1];
  assign dut_b    = idx_q[0];
  assign vec_idx  = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign mismatch = mm_q;

endmodule

// File: doc/gate_tester.md
# gate_tester

Sequential self-test engine for any 2-input combinational gate in the logic-gates library. It sweeps all four input combinations into the gate under test, waits a programmable settle time per vector, and samples the gate output. It compares each sample against a parameterised expected truth table and reports a per-vector mismatch mask and a pass flag. It is the in-hardware counterpart to the gate modules: it drives their `a`/`b` inputs and reads back their `out`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2. Cycles each vector is held before sampling. Legal range 1..255.
- `EXPECT`, default 4'b0111 (NAND). Bit i is the expected `dut_out` for vector i, where i = {a,b}.

Ports:
- `clk` in 1. Single clock, rising edge.
- `rst` in 1. Synchronous, active-high reset.
- `start` in 1. Request a test run. Accepted only in IDLE.
- `dut_a` out 1. Drives gate input a. Equals vector index bit 1.
- `dut_b` out 1. Drives gate input b. Equals vector index bit 0.
- `dut_out` in 1. Gate output being checked.
- `busy` out 1. High while vectors are being applied.
- `done` out 1. Single-cycle pulse at the end of a run.
- `pass` out 1. High when the last completed run had no mismatches.
- `mismatch` out 4. Bit i is set when vector i failed.
- `vec_idx` out 2. Current vector index, for debug.

## Operation
- FSM states: IDLE, DRIVE, DONE.
  - IDLE with `start`=1: go to DRIVE. Set idx=0 and settle count cnt=0. Clear `mismatch` and `pass`.
  - DRIVE: drive {`dut_a`,`dut_b`}=idx and increment cnt each cycle.
    - When cnt==SETTLE_CYCLES-1: sample `dut_out`. If it differs from EXPECT[idx], set mismatch[idx].
    - At that sample, if idx==3 go to DONE. Otherwise increment idx and set cnt=0.
  - DONE: `done`=1 for one cycle. `pass` = (final mismatch == 0). Then return to IDLE.
- `start` is ignored in DRIVE and DONE. No queuing.
- In IDLE, `dut_a`/`dut_b` are 0 and `vec_idx` is 0.
- `pass` and `mismatch` hold their values from the end of DONE until the next accepted start.
- cnt is an 8-bit counter. idx is 2-bit and never wraps, because the exit happens at idx==3.
- Reset, including mid-run: state=IDLE. `dut_a`=`dut_b`=`busy`=`done`=`pass`=0, `mismatch`=0, `vec_idx`=0, cnt=0. Any partial run is discarded.

## Timing
- All outputs are registered. `dut_out` is sampled combinationally at the clock edge that ends the last settle cycle of each vector.
- Let S = SETTLE_CYCLES, with `start` accepted at edge k:
  - Cycle k+1: `busy`=1, vector 0 driven.
  - Vector i is driven for cycles k+1+i·S through k+(i+1)·S.
  - Vector i is sampled at edge k+(i+1)·S.
  - Cycle k+4S+1: `busy`=0, `done`=1. `pass` and `mismatch` are final and valid here.
- Latency from start to done is 4S+1 cycles. A new `start` is accepted in the cycle after `done`.
- The gate under test must settle within S cycles. The tester does not check for glitches between samples.

## Structure
- Shared package `gate_tester_pkg` holds:
  - the state enum (IDLE, DRIVE, DONE);
  - `NUM_VECTORS` = 4;
  - truth-table constants NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110, NOR_TT=4'b0001, XOR_TT=4'b0110, XNOR_TT=4'b1001.
- Single module with one FSM, an 8-bit settle counter and a 2-bit vector counter. No sub-module is warranted.

## Test plan
- DUT = `nand_gate`, S=2, EXPECT=NAND_TT. Pulse `start` at edge k. Required: `done` at cycle k+9, `pass`=1, `mismatch`=4'b0000, and {a,b} steps 00,01,10,11 at two cycles each.
- DUT = `nand_gate`, EXPECT=AND_TT. Required: `mismatch`=4'b1111, `pass`=0.
- `dut_out` stuck at 1, EXPECT=NAND_TT, S=1. Required: `mismatch`=4'b1000, `pass`=0, `done` at k+5.
- `start` held high throughout a run. Required: timing is unchanged. The next run begins at the edge where `done`=1 returns the FSM to IDLE, and its `busy` rises 2 cycles after the first `done`.
- Assert `rst` at cycle k+3 mid-run. Required: all outputs return to 0 on the next edge. A later start then gives a full, correct 4S+1 run.
- XOR DUT modelled in the bench, EXPECT=XOR_TT, S=255. Required: `done` at k+1021, `pass`=1, and cnt does not overflow.
